// File: rtl/loadstoreunit.sv
// MEM-stage load/store unit driving a word-wide data memory: lane extraction
// and sign/zero extension for loads, read-modify-write for byte/halfword stores.
module loadstoreunit #(
  parameter int unsigned ADDR_WIDTH = 32
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  requestValid,
  input  logic                  requestLoad,
  input  logic                  requestStore,
  input  logic [2:0]            requestFunc3,
  input  logic [ADDR_WIDTH-1:0] requestAddress,
  input  logic [31:0]           requestWriteData,
  output logic                  requestReady,
  output logic                  loadValid,
  output logic [31:0]           loadData,
  output logic                  accessFault,
  output logic [ADDR_WIDTH-1:0] faultAddress,
  output logic                  memoryReadEnable,
  output logic                  memoryWriteEnable,
  output logic [2:0]            memoryFunc3,
  output logic [ADDR_WIDTH-1:0] memoryAddress,
  output logic [31:0]           memoryWriteData,
  input  logic [31:0]           memoryReadData
);

  typedef enum logic [0:0] {
    IDLE,
    MERGE_WRITE
  } state_t;

  state_t                state;
  logic [ADDR_WIDTH-1:0] merge_address;
  logic [31:0]           merge_data;
  logic [ADDR_WIDTH-1:0] word_address;
  logic                  accept;
  logic                  illegal;
  logic                  misaligned;
  logic                  fault;
  logic                  do_load;
  logic                  do_store_word;
  logic                  do_merge;
  logic [7:0]            byte_lane;
  logic [15:0]           half_lane;
  logic [31:0]           lane_data;
  logic [31:0]           merged_word;

  assign requestReady = (state == IDLE) && !reset;
  assign accept       = requestValid && requestReady;
  assign word_address = {requestAddress[ADDR_WIDTH-1:2], 2'b00};

  always_comb begin
    illegal = 1'b0;
    if (requestLoad == requestStore)
      illegal = 1'b1;
    else if (requestStore)
      illegal = !(requestFunc3 inside {3'b000, 3'b001, 3'b010});
    else
      illegal = !(requestFunc3 inside {3'b000, 3'b001, 3'b010, 3'b100, 3'b101});
  end

  // func3[1:0] encodes access size for both signed and unsigned variants.
  always_comb begin
    misaligned = 1'b0;
    case (requestFunc3[1:0])
      2'b01:   misaligned = requestAddress[0];
      2'b10:   misaligned = (requestAddress[1:0] != 2'b00);
      default: misaligned = 1'b0;
    endcase
  end

  assign fault         = accept && (illegal || misaligned);
  assign do_load       = accept && !fault && requestLoad;
  assign do_store_word = accept && !fault && requestStore && (requestFunc3 == 3'b010);
  assign do_merge      = accept && !fault && requestStore && (requestFunc3 != 3'b010);

  assign byte_lane = memoryReadData[{requestAddress[1:0], 3'b000} +: 8];
  assign half_lane = requestAddress[1] ? memoryReadData[31:16] : memoryReadData[15:0];

  always_comb begin
    lane_data = memoryReadData;
    case (requestFunc3)
      3'b000:  lane_data = {{24{byte_lane[7]}}, byte_lane};
      3'b001:  lane_data = {{16{half_lane[15]}}, half_lane};
      3'b100:  lane_data = {24'd0, byte_lane};
      3'b101:  lane_data = {16'd0, half_lane};
      default: lane_data = memoryReadData;
    endcase
  end

  always_comb begin
    merged_word = memoryReadData;
    if (requestFunc3[0]) begin
      if (requestAddress[1])
        merged_word[31:16] = requestWriteData[15:0];
      else
        merged_word[15:0] = requestWriteData[15:0];
    end else begin
      merged_word[{requestAddress[1:0], 3'b000} +: 8] = requestWriteData[7:0];
    end
  end

  // A merge write still in flight is dropped if reset arrives in its cycle.
  assign memoryFunc3       = 3'b010;
  assign memoryReadEnable  = do_load || do_merge;
  assign memoryWriteEnable = !reset && ((state == MERGE_WRITE) || do_store_word);
  assign memoryAddress     = (state == MERGE_WRITE) ? merge_address : word_address;
  assign memoryWriteData   = (state == MERGE_WRITE) ? merge_data : requestWriteData;

  always_ff @(posedge clock) begin
    if (reset) begin
      state        <= IDLE;
      loadValid    <= 1'b0;
      loadData     <= '0;
      accessFault  <= 1'b0;
      faultAddress <= '0;
    end else begin
      loadValid   <= do_load;
      accessFault <= fault;
      if (do_load)
        loadData <= lane_data;
      if (fault)
        faultAddress <= requestAddress;
      case (state)
        IDLE: begin
          if (do_merge) begin
            state         <= MERGE_WRITE;
            merge_address <= word_address;
            merge_data    <= merged_word;
          end
        end
        MERGE_WRITE: state <= IDLE;
        default:     state <= IDLE;
      endcase
    end
  end

endmodule
